// File: rtl/pre_dct_pkg.sv
// Shared defaults and types for the pre-DCT level-shift stage.
package pre_dct_pkg;
  localparam int DEF_IN_WIDTH  = 10;
  localparam int DEF_OUT_WIDTH = 32;
  localparam int DEF_N         = 8;

  function automatic int offset_of(input int in_w);
    return 1 << (in_w - 1);
  endfunction

  typedef logic signed [DEF_N-1:0][DEF_N-1:0][DEF_OUT_WIDTH-1:0] block_t;
endpackage

// File: rtl/pre_dct_bank.sv
// One N x N block buffer: row write port, full flag and per-block shift flag.
module pre_dct_bank #(
  parameter int N         = 8,
  parameter int OUT_WIDTH = 32,
  parameter int RW        = 3
) (
  input  logic                                CLOCK,
  input  logic                                RESET,
  input  logic                                wr_en,
  input  logic [RW-1:0]                       wr_row,
  input  logic [N-1:0][OUT_WIDTH-1:0]         wr_data,
  input  logic                                shift_ld,
  input  logic                                shift_in,
  input  logic                                fill,
  input  logic                                clear,
  output logic [N-1:0][N-1:0][OUT_WIDTH-1:0]  data,
  output logic                                full,
  output logic                                shift
);
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      data  <= '0;
      full  <= 1'b0;
      shift <= 1'b0;
    end else begin
      if (wr_en)    data[wr_row] <= wr_data;
      if (shift_ld) shift <= shift_in;
      // fill and clear never target the same bank in one cycle
      if (fill)       full <= 1'b1;
      else if (clear) full <= 1'b0;
    end
  end
endmodule

// File: rtl/pre_dct_stream.sv
// Row-streaming level shifter: assembles N rows into a ping-pong N x N block for the DCT.
module pre_dct_stream
  import pre_dct_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int N         = DEF_N,
  parameter int OFFSET    = offset_of(IN_WIDTH)
) (
  input  logic                               CLOCK,
  input  logic                               RESET,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_sop,
  input  logic                               shift_en,
  input  logic [N-1:0][IN_WIDTH-1:0]         INPUT_DATA,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [N-1:0][N-1:0][OUT_WIDTH-1:0] OUTPUT_DATA,
  output logic                               sop_err
);
  localparam int RW = $clog2(N);

  if (OUT_WIDTH < IN_WIDTH + 1 || N < 2) begin : g_bad_param
    $error("pre_dct_stream: need OUT_WIDTH >= IN_WIDTH+1 and N >= 2");
  end

  logic [RW-1:0] r, row_idx;
  logic          wr_ptr, rd_ptr, init_q;
  logic          accept, consume, last, shift_cur;
  logic [N-1:0][OUT_WIDTH-1:0]         row_data;
  logic [1:0][N-1:0][N-1:0][OUT_WIDTH-1:0] bank_data;
  logic [1:0]    bank_full, bank_shift;

  assign in_ready    = init_q && !bank_full[wr_ptr];
  assign out_valid   = bank_full[rd_ptr];
  assign OUTPUT_DATA = bank_data[rd_ptr];
  assign accept      = in_valid && in_ready;
  assign consume     = out_valid && out_ready;
  // in_sop restarts framing: the row lands as row 0 regardless of the counter
  assign row_idx     = in_sop ? '0 : r;
  assign last        = accept && (row_idx == RW'(N-1));
  assign shift_cur   = (row_idx == '0) ? shift_en : bank_shift[wr_ptr];

  always_comb begin
    row_data = '0;
    for (int c = 0; c < N; c++)
      row_data[c] = OUT_WIDTH'(INPUT_DATA[c]) - (shift_cur ? OUT_WIDTH'(OFFSET) : '0);
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pre_dct_bank #(.N(N), .OUT_WIDTH(OUT_WIDTH), .RW(RW)) u_bank (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .wr_en    (accept && (wr_ptr == 1'(b))),
      .wr_row   (row_idx),
      .wr_data  (row_data),
      .shift_ld (accept && (wr_ptr == 1'(b)) && (row_idx == '0)),
      .shift_in (shift_en),
      .fill     (last && (wr_ptr == 1'(b))),
      .clear    (consume && (rd_ptr == 1'(b))),
      .data     (bank_data[b]),
      .full     (bank_full[b]),
      .shift    (bank_shift[b])
    );
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r       <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      init_q  <= 1'b0;
      sop_err <= 1'b0;
    end else begin
      init_q  <= 1'b1;
      sop_err <= accept && in_sop && (r != '0);
      if (accept) begin
        if (last) begin
          r      <= '0;
          wr_ptr <= ~wr_ptr;
        end else begin
          r <= row_idx + RW'(1);
        end
      end
      if (consume) rd_ptr <= ~rd_ptr;
    end
  end
endmodule

// File: tb/tb_pre_dct_stream.sv
// Randomized + directed bench for pre_dct_stream against a queue-based block model.
module tb_pre_dct_stream;
  import pre_dct_pkg::*;
  localparam int IW = 10, OW = 32, N = 8, OFF = 512;
  localparam int IW2 = 12, OW2 = 16, N2 = 4;

  logic CLOCK = 1'b0, RESET = 1'b0;
  always #5 CLOCK = ~CLOCK;

  logic in_valid = 0, in_sop = 0, shift_en = 0, out_ready = 0;
  logic in_ready, out_valid, sop_err;
  logic [N-1:0][IW-1:0] INPUT_DATA = '0;
  logic [N-1:0][N-1:0][OW-1:0] OUTPUT_DATA;

  logic in_valid2 = 0, in_sop2 = 0, shift_en2 = 0, out_ready2 = 0;
  logic in_ready2, out_valid2, sop_err2;
  logic [N2-1:0][IW2-1:0] INPUT_DATA2 = '0;
  logic [N2-1:0][N2-1:0][OW2-1:0] OUTPUT_DATA2;

  pre_dct_stream dut (
    .CLOCK(CLOCK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .in_sop(in_sop), .shift_en(shift_en), .INPUT_DATA(INPUT_DATA),
    .out_valid(out_valid), .out_ready(out_ready), .OUTPUT_DATA(OUTPUT_DATA),
    .sop_err(sop_err));

  pre_dct_stream #(.IN_WIDTH(IW2), .OUT_WIDTH(OW2), .N(N2)) dut2 (
    .CLOCK(CLOCK), .RESET(RESET), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_sop(in_sop2), .shift_en(shift_en2), .INPUT_DATA(INPUT_DATA2),
    .out_valid(out_valid2), .out_ready(out_ready2), .OUTPUT_DATA(OUTPUT_DATA2),
    .sop_err(sop_err2));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: completed blocks waiting for the consumer, plus the block being assembled.
  block_t q[$];
  block_t cur;
  int     cnt = 0;
  logic   sflag = 0, sop_m = 0, init_m = 0;

  task automatic do_reset();
    RESET = 0; in_valid = 0; in_sop = 0; out_ready = 0;
    @(posedge CLOCK); #1;
    @(negedge CLOCK);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sop_err", sop_err, 0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        chk("rst_data", 64'(OUTPUT_DATA[r][c]), 0);
    q.delete(); cnt = 0; sop_m = 0; sflag = 0;
    RESET = 1;
    @(posedge CLOCK); #1;
    init_m = 1;
  endtask

  task automatic cycle(input logic v, input logic sop, input logic sh,
                       input logic [N-1:0][IW-1:0] d, input logic ordy);
    logic acc, cons;
    in_valid = v; in_sop = sop; shift_en = sh; INPUT_DATA = d; out_ready = ordy;
    @(negedge CLOCK);
    chk("in_ready", in_ready, 64'(init_m && q.size() < 2));
    chk("out_valid", out_valid, 64'(q.size() > 0));
    chk("sop_err", sop_err, sop_m);
    if (q.size() > 0)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          chk("data", 64'(OUTPUT_DATA[r][c]), 64'(q[0][r][c]));
    acc  = v && init_m && q.size() < 2;
    cons = ordy && q.size() > 0;
    @(posedge CLOCK); #1;
    if (cons) void'(q.pop_front());
    sop_m = 0;
    if (acc) begin
      if (sop && cnt != 0) begin sop_m = 1; cnt = 0; end
      if (cnt == 0) sflag = sh;
      for (int c = 0; c < N; c++)
        cur[cnt][c] = OW'(int'(d[c]) - (sflag ? OFF : 0));
      cnt++;
      if (cnt == N) begin q.push_back(cur); cnt = 0; end
    end
  endtask

  function automatic logic [N-1:0][IW-1:0] pat_row(input int i);
    logic [N-1:0][IW-1:0] d;
    for (int c = 0; c < N; c++)
      case ((i + c) % 3)
        0: d[c] = 10'h000;
        1: d[c] = 10'h200;
        default: d[c] = 10'h3FF;
      endcase
    return d;
  endfunction

  function automatic logic [N-1:0][IW-1:0] rnd_row();
    logic [N-1:0][IW-1:0] d;
    for (int c = 0; c < N; c++) d[c] = IW'($urandom_range(0, 1023));
    return d;
  endfunction

  initial begin
    do_reset();

    // Pattern block with shift, explicit boundary values checked after the last row
    for (int i = 0; i < N; i++) cycle(1, i == 0, 1, pat_row(i), 0);
    in_valid = 0;
    @(negedge CLOCK);
    chk("lat_out_valid", out_valid, 1);
    chk("min_val", 64'(OUTPUT_DATA[0][0]), 64'(32'hFFFF_FE00));
    chk("mid_val", 64'(OUTPUT_DATA[0][1]), 64'(32'h0000_0000));
    chk("max_val", 64'(OUTPUT_DATA[0][2]), 64'(32'h0000_01FF));
    @(posedge CLOCK); #1;
    cycle(0, 0, 0, '0, 1);

    // Block A unshifted with shift_en toggling mid-block, block B shifted
    for (int i = 0; i < N; i++) cycle(1, 0, (i == 0) ? 1'b0 : 1'(i % 2), rnd_row(), 1);
    for (int i = 0; i < N; i++) cycle(1, 0, (i == 0) ? 1'b1 : 1'(i % 2 == 0), rnd_row(), 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1);

    // Back-pressure: three blocks streamed with out_ready low, then drained
    for (int i = 0; i < 3 * N; i++) cycle(1, 0, 1, rnd_row(), 0);
    for (int i = 0; i < 3 * N + 4; i++) cycle(i >= 3 && i < N + 3, 0, 1, rnd_row(), 1);
    for (int i = 0; i < 2 * N; i++) cycle(0, 0, 0, '0, 1);

    // Resync: in_sop at row 5
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, rnd_row(), 1);
    for (int i = 0; i < N; i++) cycle(1, i == 0, 1, rnd_row(), 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1);

    // Reset with one full block pending and four rows partial
    for (int i = 0; i < N + 4; i++) cycle(1, 0, 1, rnd_row(), 0);
    do_reset();
    for (int i = 0; i < N + 2; i++) cycle(i < N, 0, 1, rnd_row(), 0);
    cycle(0, 0, 0, '0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 1'($urandom),
            rnd_row(), $urandom_range(0, 2) != 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0, 1);

    // Second parameter set: IN_WIDTH=12, N=4, OUT_WIDTH=16
    for (int i = 0; i < N2; i++) begin
      in_valid2 = 1; in_sop2 = (i == 0); shift_en2 = 1;
      for (int c = 0; c < N2; c++) INPUT_DATA2[c] = (c % 2 == 0) ? 12'h000 : 12'hFFF;
      @(negedge CLOCK);
      chk("p2_in_ready", in_ready2, 1);
      chk("p2_out_valid_early", out_valid2, 0);
      @(posedge CLOCK); #1;
    end
    in_valid2 = 0;
    @(negedge CLOCK);
    chk("p2_out_valid", out_valid2, 1);
    for (int r = 0; r < N2; r++)
      for (int c = 0; c < N2; c++)
        chk("p2_data", 64'(OUTPUT_DATA2[r][c]), (c % 2 == 0) ? 64'(16'hF800) : 64'(16'h07FF));
    out_ready2 = 1;
    @(posedge CLOCK); #1;
    @(negedge CLOCK);
    chk("p2_consumed", out_valid2, 0);
    out_ready2 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
